branch_recovery: RTL and testbench
==================================

BRANCH_RECOVERY -- requirements
Module: branch_recovery

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles the flush pulse is held (legal range 1..15).
REQ-002 Parameters RSV_ID_W, CRAM_ADDR_W SHALL come from fcpu_pkg.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port nrst, input, 1, asynchronous active-low reset.
REQ-006 Port miss_valid, input, 1, branch unit reports a mispredict this cycle.
REQ-007 Port miss_tag, input, RSV_ID_W, ROB tag of the mispredicted branch.
REQ-008 Port miss_dst, input, CRAM_ADDR_W, corrected fetch address.
REQ-009 Port rob_head_valid, input, 1, ROB head entry valid.
REQ-010 Port rob_head_tag, input, RSV_ID_W, tag of the ROB head entry.
REQ-011 Port fetch_ready, input, 1, fetch accepts a redirect.
REQ-012 Port stall_fetch, output, 1, dispatch/fetch hold.
REQ-013 Port flush, output, 1, clear ROB, reservation stations and CDB-pending state.
REQ-014 Port redirect_valid, output, 1, redirect request to fetch.
REQ-015 Port redirect_pc, output, CRAM_ADDR_W, redirect target.
REQ-016 Port miss_count, output, 8, count of recoveries completed, saturating.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_HEAD, FLUSH and REDIRECT, all registered.
REQ-018 IDLE, miss_valid=1: latch tag/dst; next state WAIT_HEAD.
REQ-019 WAIT_HEAD: when rob_head_valid=1 and rob_head_tag==saved tag, next state FLUSH and flush counter loaded with FLUSH_CYCLES-1.
REQ-020 WAIT_HEAD, miss_valid=1: replace the saved tag/dst iff (miss_tag-rob_head_tag) mod 2^RSV_ID_W < (saved_tag-rob_head_tag) mod 2^RSV_ID_W (older branch wins); otherwise ignore; unsigned RSV_ID_W-bit wrap arithmetic.
REQ-021 WAIT_HEAD, a replacing miss and the head match for the old tag in the same cycle: replacement wins and the state stays WAIT_HEAD.
REQ-022 FLUSH: flush=1 for exactly FLUSH_CYCLES consecutive cycles, then next state REDIRECT.
REQ-023 REDIRECT: redirect_valid=1 and redirect_pc=saved dst, held stable until fetch_ready=1; on that cycle the handshake completes, next state IDLE, and miss_count increments unless it is 255.
REQ-024 miss_valid in FLUSH or REDIRECT SHALL be ignored (wrong-path result).
REQ-025 stall_fetch=1 in every state except IDLE; it is a registered-state decode, with no combinational path from inputs.
REQ-026 flush, redirect_valid and redirect_pc SHALL depend only on registered state, with no input-to-output combinational path.
REQ-027 redirect_pc=0 when redirect_valid=0.
REQ-028 Latency from miss_valid in IDLE with the branch already at head: flush is first high 2 cycles later (WAIT_HEAD lasts 1 cycle).

Reset
REQ-029 nrst low SHALL asynchronously force IDLE, stall_fetch=0, flush=0, redirect_valid=0, redirect_pc=0, miss_count=0, saved tag/dst=0, flush counter=0.
REQ-030 Reset asserted mid-recovery SHALL abort it with no redirect issued; the first miss after deassertion SHALL be handled normally.
REQ-031 Reset deassertion is synchronised externally; the block SHALL not act on inputs in the cycle nrst rises.

Verification
REQ-032 RSV_ID_W=4, FLUSH_CYCLES=2: miss tag=3, dst=0x040; head=3 the next cycle -> flush high for 2 cycles, then redirect_pc=0x040; fetch_ready=1 -> IDLE, miss_count=1.
REQ-033 Head=1; miss tag=5 saved; then miss tag=2 in WAIT_HEAD -> replaces (distance 1<4); miss tag=7 next -> ignored; redirect to the tag-2 dst.
REQ-034 Wrap: head=14; saved tag=1 (distance 3); new miss tag=15 (distance 1) -> replaces.
REQ-035 fetch_ready low for 5 cycles in REDIRECT -> redirect_valid/pc stable for 5 cycles, stall_fetch=1 throughout; miss_valid in those cycles ignored.
REQ-036 nrst pulsed low during FLUSH -> all outputs 0 immediately without a clock edge; no redirect follows.
REQ-037 Complete 256 recoveries -> miss_count=255 and holds.

Source files
------------

// File: rtl/branch_recovery.sv
// Branch mispredict recovery: waits for the mispredicted branch to reach the ROB head,
// pulses flush, then redirects fetch to the corrected address.
package fcpu_pkg;
  parameter int unsigned RSV_ID_W    = 4;
  parameter int unsigned CRAM_ADDR_W = 12;
endpackage

module branch_recovery
  import fcpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   miss_valid,
  input  logic [RSV_ID_W-1:0]    miss_tag,
  input  logic [CRAM_ADDR_W-1:0] miss_dst,
  input  logic                   rob_head_valid,
  input  logic [RSV_ID_W-1:0]    rob_head_tag,
  input  logic                   fetch_ready,
  output logic                   stall_fetch,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [CRAM_ADDR_W-1:0] redirect_pc,
  output logic [7:0]             miss_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MC_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_HEAD = 2'd1,
    S_FLUSH     = 2'd2,
    S_REDIRECT  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [RSV_ID_W-1:0]    tag_q, tag_d;
  logic [CRAM_ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [MC_W-1:0]        mc_q, mc_d;
  logic                   stall_q, stall_d;
  logic                   flush_q, flush_d;
  logic                   rv_q, rv_d;
  logic [CRAM_ADDR_W-1:0] rpc_q, rpc_d;
  logic [RSV_ID_W-1:0]    dist_new, dist_old;

  // Next state; outputs are precomputed from state_d so they stay pure flop outputs
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    dst_d    = dst_q;
    fcnt_d   = fcnt_q;
    mc_d     = mc_q;
    // Age relative to the ROB head, modulo the tag space: smaller is older
    dist_new = miss_tag - rob_head_tag;
    dist_old = tag_q - rob_head_tag;

    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          tag_d   = miss_tag;
          dst_d   = miss_dst;
          state_d = S_WAIT_HEAD;
        end
      end
      S_WAIT_HEAD: begin
        if (miss_valid && (dist_new < dist_old)) begin
          tag_d = miss_tag;
          dst_d = miss_dst;
        end else if (rob_head_valid && (rob_head_tag == tag_q)) begin
          state_d = S_FLUSH;
          fcnt_d  = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_REDIRECT;
        end else begin
          fcnt_d = fcnt_q - CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        if (fetch_ready) begin
          state_d = S_IDLE;
          if (mc_q != {MC_W{1'b1}}) begin
            mc_d = mc_q + MC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    stall_d = (state_d != S_IDLE);
    flush_d = (state_d == S_FLUSH);
    rv_d    = (state_d == S_REDIRECT);
    rpc_d   = rv_d ? dst_d : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      dst_q   <= '0;
      fcnt_q  <= '0;
      mc_q    <= '0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      dst_q   <= dst_d;
      fcnt_q  <= fcnt_d;
      mc_q    <= mc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  assign stall_fetch    = stall_q;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign miss_count     = mc_q;

endmodule

// File: tb/tb_branch_recovery.sv
// Scoreboard bench for branch_recovery: stimulus pushes expected redirects,
// a monitor pops them on each fetch handshake and also checks flush pulse length.
module tb_branch_recovery;
  localparam int unsigned FC = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        miss_valid;
  logic [3:0]  miss_tag;
  logic [11:0] miss_dst;
  logic        rob_head_valid;
  logic [3:0]  rob_head_tag;
  logic        fetch_ready;
  logic        stall_fetch;
  logic        flush;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic [7:0]  miss_count;

  typedef struct {
    logic [11:0] pc;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  bit   done = 1'b0;

  branch_recovery #(.FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .miss_valid     (miss_valid),
    .miss_tag       (miss_tag),
    .miss_dst       (miss_dst),
    .rob_head_valid (rob_head_valid),
    .rob_head_tag   (rob_head_tag),
    .fetch_ready    (fetch_ready),
    .stall_fetch    (stall_fetch),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [11:0] pc);
    exp_t e;
    model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    e.pc  = pc;
    e.cnt = 8'(model_cnt);
    exp_q.push_back(e);
  endtask

  // Present a miss whose branch is already at the ROB head and complete the redirect
  task automatic recover(input logic [3:0] tag, input logic [11:0] dst, input int hold);
    int n;
    rob_head_valid = 1'b1;
    rob_head_tag   = tag;
    miss_valid     = 1'b1;
    miss_tag       = tag;
    miss_dst       = dst;
    tick();
    miss_valid = 1'b0;
    n = 0;
    while (!redirect_valid && n < 20) begin
      tick();
      n++;
    end
    if (!redirect_valid) chk("redirect_timeout", 32'(redirect_valid), 32'(1));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(redirect_valid), 32'(1));
      chk("hold_pc", 32'(redirect_pc), 32'(dst));
      chk("hold_stall", 32'(stall_fetch), 32'(1));
      miss_valid = 1'b1;
      miss_tag   = 4'(tag + 4'(1));
      miss_dst   = 12'hBAD;
      tick();
      miss_valid = 1'b0;
    end
    push_expected(dst);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
  endtask

  task automatic wait_redirect_and_accept(input logic [11:0] dst);
    int n;
    n = 0;
    while (!redirect_valid && n < 20) begin
      tick();
      n++;
    end
    chk("redirect_seen", 32'(redirect_valid), 32'(1));
    push_expected(dst);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    tick();
  endtask

  task automatic monitor();
    int   run_len;
    bit   pend;
    logic [7:0] pend_cnt;
    exp_t e;
    run_len = 0;
    pend = 1'b0;
    pend_cnt = '0;
    while (!done) begin
      @(negedge clk);
      if (!nrst) begin
        run_len = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("miss_count", 32'(miss_count), 32'(pend_cnt));
          pend = 1'b0;
        end
        if (redirect_valid && fetch_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_redirect", 32'(redirect_pc), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("redirect_pc", 32'(redirect_pc), 32'(e.pc));
            pend = 1'b1;
            pend_cnt = e.cnt;
          end
        end
        if (flush) begin
          run_len++;
        end else if (run_len > 0) begin
          chk("flush_len", 32'(run_len), 32'(FC));
          run_len = 0;
        end
      end
    end
  endtask

  task automatic stimulus();
    int n;
    nrst = 1'b0;
    miss_valid = 1'b0;
    miss_tag = '0;
    miss_dst = '0;
    rob_head_valid = 1'b0;
    rob_head_tag = '0;
    fetch_ready = 1'b0;
    #3;
    chk("rst_stall", 32'(stall_fetch), 32'(0));
    chk("rst_flush", 32'(flush), 32'(0));
    chk("rst_rv", 32'(redirect_valid), 32'(0));
    chk("rst_pc", 32'(redirect_pc), 32'(0));
    chk("rst_count", 32'(miss_count), 32'(0));
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    tick();

    // Basic recovery with exact latency: tag 3, dst 0x040
    miss_valid = 1'b1; miss_tag = 4'd3; miss_dst = 12'h040;
    tick();
    miss_valid = 1'b0; rob_head_valid = 1'b1; rob_head_tag = 4'd3;
    chk("lat_wait_stall", 32'(stall_fetch), 32'(1));
    chk("lat_wait_flush", 32'(flush), 32'(0));
    chk("lat_wait_rv", 32'(redirect_valid), 32'(0));
    tick();
    chk("lat_flush1", 32'(flush), 32'(1));
    tick();
    chk("lat_flush2", 32'(flush), 32'(1));
    tick();
    chk("lat_flush_end", 32'(flush), 32'(0));
    chk("lat_rv", 32'(redirect_valid), 32'(1));
    chk("lat_pc", 32'(redirect_pc), 32'h040);
    push_expected(12'h040);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    chk("idle_rv", 32'(redirect_valid), 32'(0));
    chk("idle_pc", 32'(redirect_pc), 32'(0));
    chk("idle_stall", 32'(stall_fetch), 32'(0));
    tick();

    // Older branch replaces, younger one ignored
    rob_head_valid = 1'b1; rob_head_tag = 4'd1;
    miss_valid = 1'b1; miss_tag = 4'd5; miss_dst = 12'h111;
    tick();
    miss_tag = 4'd2; miss_dst = 12'h222;
    tick();
    miss_tag = 4'd7; miss_dst = 12'h777;
    tick();
    miss_valid = 1'b0;
    chk("older_no_flush", 32'(flush), 32'(0));
    rob_head_tag = 4'd2;
    wait_redirect_and_accept(12'h222);

    // Tag wraparound: head 14, tag 15 is older than tag 1
    rob_head_tag = 4'd14;
    miss_valid = 1'b1; miss_tag = 4'd1; miss_dst = 12'h333;
    tick();
    miss_tag = 4'd15; miss_dst = 12'h444;
    tick();
    miss_valid = 1'b0;
    rob_head_tag = 4'd15;
    wait_redirect_and_accept(12'h444);

    // Fetch back-pressure for 5 cycles with wrong-path misses
    recover(4'd9, 12'h5A5, 5);
    tick();

    // Reset during flush aborts the recovery
    rob_head_valid = 1'b1; rob_head_tag = 4'd6;
    miss_valid = 1'b1; miss_tag = 4'd6; miss_dst = 12'h666;
    tick();
    miss_valid = 1'b0;
    n = 0;
    while (!flush && n < 10) begin
      tick();
      n++;
    end
    chk("pre_abort_flush", 32'(flush), 32'(1));
    #2 nrst = 1'b0;
    #1;
    chk("abort_stall", 32'(stall_fetch), 32'(0));
    chk("abort_flush", 32'(flush), 32'(0));
    chk("abort_rv", 32'(redirect_valid), 32'(0));
    chk("abort_pc", 32'(redirect_pc), 32'(0));
    chk("abort_count", 32'(miss_count), 32'(0));
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    fetch_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_abort_rv", 32'(redirect_valid), 32'(0));
    end
    fetch_ready = 1'b0;

    // First miss after reset, then saturate the counter
    recover(4'd6, 12'h0AB, 0);
    for (int i = 0; i < 256; i++) begin
      recover(4'(i), 12'(i * 3), 0);
    end
    tick();
    tick();
    chk("sat_count", 32'(miss_count), 32'd255);
    chk("sb_drain", 32'(exp_q.size()), 32'(0));
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
